// File: rtl/shift_array_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : shift_array_stream_ctrl
// Brief   : Valid/ready stream wrapper around an external DEPTH-position shift
//           register array. A tag pipeline tracks which array slots hold real
//           words. Flush drains held words by inserting zero-filled bubbles.
// Revision: 1.0 - initial release
// ============================================================================
module shift_array_stream_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [BIT_WIDTH-1:0]         shift_in,
  output logic                         shift_enable,
  input  logic [BIT_WIDTH-1:0]         shift_out,
  output logic [BIT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drain_done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DEPTH-1:0]     r_tag;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_next;
  logic                 r_drain_done;
  logic                 w_drain_done_next;
  logic                 w_fire_in;
  logic                 w_fire_out;
  logic                 w_bubble;

  // Handshake decode and array strobe generation
  always_comb begin
    out_valid    = r_tag[DEPTH-1];
    out_data     = shift_out;
    in_ready     = (r_state == RUN) && (!out_valid || out_ready) && reset;
    w_fire_in    = in_valid && in_ready;
    w_fire_out   = out_valid && out_ready;
    // While draining, push zero bubbles until the next real word surfaces
    w_bubble     = (r_state == DRAIN) && (r_count != '0) && !out_valid;
    shift_enable = w_fire_in || w_fire_out || w_bubble;
    shift_in     = w_fire_in ? in_data : '0;
    count        = r_count;
    drain_done   = r_drain_done;
  end

  // Occupancy update, saturating at both ends
  always_comb begin
    w_count_next = r_count;
    if (w_fire_in && !w_fire_out && (r_count != c_full)) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_fire_in && w_fire_out && (r_count != '0)) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Tag pipeline mirrors the external array, one bit per slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag <= '0;
    end else if (shift_enable) begin
      r_tag <= {r_tag[DEPTH-2:0], w_fire_in};
    end
  end

  // Held-word counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // FSM state and registered drain completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_drain_done <= w_drain_done_next;
    end
  end

  // Next-state logic: flush counts a word accepted in the same cycle
  always_comb begin
    w_state_next      = r_state;
    w_drain_done_next = 1'b0;
    case (r_state)
      RUN: begin
        if (flush && (w_count_next != '0)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next      = RUN;
          w_drain_done_next = 1'b1;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_array_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_array_stream_ctrl
// Brief   : Scoreboard bench with an external shift array model and a
//           word-level reference model of the stream controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_array_stream_ctrl;

  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [BW-1:0] shift_in;
  logic          shift_enable;
  logic [BW-1:0] shift_out;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          drain_done;

  int total = 0;
  int bad   = 0;

  shift_array_stream_ctrl #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .shift_in(shift_in),
    .shift_enable(shift_enable), .shift_out(shift_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  // External shift register array driven by the controller
  logic [BW-1:0] arr [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) arr[i] = '0;
  always @(posedge clk) begin
    if (shift_enable) begin
      for (int i = DEPTH-1; i > 0; i--) arr[i] <= arr[i-1];
      arr[0] <= shift_in;
    end
  end
  assign shift_out = arr[DEPTH-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each held word remembers the strobe number that inserted
  // it; it is visible at the array output once DEPTH-1 further strobes passed.
  logic [BW-1:0] sb [$];
  int            stamps [$];
  int            nstrobe  = 0;
  bit            draining = 0;
  bit            e_dd     = 0;

  always @(negedge clk) begin
    bit e_ov, e_ir, f_in, f_out, e_se;
    if (!reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_shift_en", shift_enable, 0);
      chk("rst_count", count, 0);
      chk("rst_drain_done", drain_done, 0);
      stamps.delete();
      sb.delete();
      draining = 0;
      e_dd     = 0;
    end else begin
      e_ov  = (stamps.size() != 0) && (nstrobe - stamps[0] == DEPTH-1);
      e_ir  = !draining && (!e_ov || out_ready);
      f_in  = in_valid && e_ir;
      f_out = e_ov && out_ready;
      e_se  = f_in || f_out || (draining && stamps.size() != 0 && !e_ov);
      chk("out_valid", out_valid, e_ov);
      chk("in_ready", in_ready, e_ir);
      chk("shift_enable", shift_enable, e_se);
      chk("count", count, stamps.size());
      chk("drain_done", drain_done, e_dd);
      if (e_se) chk("shift_in", shift_in, f_in ? in_data : 8'h00);
      if (e_se) nstrobe++;
      if (f_in) begin
        stamps.push_back(nstrobe);
        sb.push_back(in_data);
      end
      if (f_out) void'(stamps.pop_front());
      e_dd = 0;
      if (draining && stamps.size() == 0) begin
        draining = 0;
        e_dd     = 1;
      end else if (!draining && flush && stamps.size() != 0) begin
        draining = 1;
      end
    end
  end

  // Monitor: every word the DUT hands downstream must be the oldest accepted
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_data: got %0h expected nothing (scoreboard empty)", out_data);
      end else begin
        chk("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] w);
    bit ok = 0;
    int n  = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    bit seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = drain_done;
    end
    chk("drain_done_seen", seen, 1);
    step();
  endtask

  initial begin
    logic [BW-1:0] held;
    logic [CW-1:0] hc;
    repeat (3) step();
    reset = 1'b1;

    // Fill with downstream stalled
    out_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_out_data", out_data, 8'h11);
    chk("fill_count", count, DEPTH);
    chk("fill_in_ready", in_ready, 0);
    step();

    // Streaming from full
    out_ready = 1'b1;
    send(8'h55); send(8'h66);
    out_ready = 1'b0;
    @(negedge clk);
    chk("stream_count", count, DEPTH);
    step();

    // Full drain with downstream ready
    out_ready = 1'b1;
    pulse_flush();
    wait_drain();

    // Drain with backpressure while a real word waits at the output
    out_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    pulse_flush();
    @(negedge clk);
    held = out_data;
    hc   = count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_data", out_data, held);
      chk("bp_count", count, hc);
      chk("bp_shift_en", shift_enable, 0);
    end
    step();
    out_ready = 1'b1;
    wait_drain();

    // Partial drain through bubbles
    send(8'hA1); send(8'hA2);
    pulse_flush();
    wait_drain();

    // Reset in the middle of a drain
    send(8'hB1); send(8'hB2);
    pulse_flush();
    chk("mid_count", count, 2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_shift_en", shift_enable, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    step();
    reset = 1'b1;
    repeat (DEPTH + 4) step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = BW'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 4);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH * 4) step();
    pulse_flush();
    repeat (DEPTH * 4) step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_array_stream_ctrl.md
SHIFT_ARRAY_STREAM_CTRL -- requirements
Module: shift_array_stream_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, word width.
REQ-002 SHALL have parameter DEPTH, default 8, number of shift positions in the driven shift-register array (DEPTH >= 2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, BIT_WIDTH, upstream word.
REQ-006 SHALL have port in_valid, input, 1, upstream word valid.
REQ-007 SHALL have port in_ready, output, 1, word accepted this cycle when in_valid && in_ready.
REQ-008 SHALL have port flush, input, 1, request to drain all held words.
REQ-009 SHALL have port shift_in, output, BIT_WIDTH, word fed to the array input.
REQ-010 SHALL have port shift_enable, output, 1, array shift strobe.
REQ-011 SHALL have port shift_out, input, BIT_WIDTH, array output; equals the word inserted DEPTH strobes earlier.
REQ-012 SHALL have port out_data, output, BIT_WIDTH, downstream word.
REQ-013 SHALL have port out_valid, output, 1, downstream word valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accept.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1), number of real words held (0..DEPTH).
REQ-016 SHALL have port drain_done, output, 1, one-cycle pulse at end of drain.

Function
REQ-017 SHALL keep a DEPTH-bit tag register shifting in lockstep with shift_enable; tag[DEPTH-1] marks a real word at shift_out.
REQ-018 SHALL drive out_valid = tag[DEPTH-1] and out_data = shift_out, both combinational.
REQ-019 SHALL implement FSM states RUN and DRAIN.
REQ-020 SHALL drive in_ready = (state == RUN) && (!out_valid || out_ready) && reset.
REQ-021 SHALL define fire_in = in_valid && in_ready and fire_out = out_valid && out_ready.
REQ-022 SHALL assert shift_enable = fire_in || fire_out || (DRAIN && count != 0 && !out_valid), combinationally.
REQ-023 SHALL drive shift_in = in_data on fire_in, else all zeros; new tag bit = fire_in.
REQ-024 SHALL update count by +fire_in - fire_out per cycle, never exceeding DEPTH or going below 0.
REQ-025 SHALL hold all state when shift_enable is 0; no word shall ever be lost or emitted twice.
REQ-026 SHALL transition RUN -> DRAIN when flush == 1 and count (after this cycle's update) != 0; a word accepted in the same cycle as flush is included in the drain.
REQ-027 SHALL ignore flush when count would be 0 (stay in RUN, no drain_done).
REQ-028 SHALL ignore flush while in DRAIN.
REQ-029 SHALL transition DRAIN -> RUN on the cycle count reaches 0, pulsing drain_done for exactly one cycle (registered, first cycle back in RUN).
REQ-030 SHALL make end-to-end latency exactly DEPTH shift strobes; when neither side fires in RUN, no shift occurs.

Reset
REQ-031 SHALL, while reset is low, asynchronously force tags = 0, count = 0, state = RUN, drain_done = 0, giving out_valid = 0, shift_enable = 0, in_ready = 0.
REQ-032 SHALL, on the first cycle after reset deasserts, present in_ready = 1 with no other action required.
REQ-033 SHALL abandon any drain in progress on reset without emitting drain_done.

Verification (DEPTH=4, BIT_WIDTH=8)
REQ-034 SHALL cover fill: reset, out_ready=0, send 0x11,0x22,0x33,0x44 -> 4 strobes; then out_valid=1, out_data=0x11, count=4, in_ready=0.
REQ-035 SHALL cover streaming: from full, out_ready=1, in_valid=1 with 0x55,0x66 -> outputs 0x11,0x22 on consecutive cycles, count stays 4, shift_enable=1 each cycle.
REQ-036 SHALL cover drain: full with 0x11..0x44, flush pulse, out_ready=1 -> in_ready=0, outputs 0x11,0x22,0x33,0x44 in order, count 4->0, drain_done one cycle, then in_ready=1.
REQ-037 SHALL cover partial drain with bubbles: accept 0xA1,0xA2 then flush, out_ready=1 -> zero-filled strobes until 0xA1 reaches shift_out, outputs 0xA1,0xA2, then drain_done.
REQ-038 SHALL cover backpressure: DRAIN with out_valid=1, out_ready=0 for 3 cycles -> shift_enable=0, out_data stable, count unchanged.
REQ-039 SHALL cover reset mid-drain: reset low during DRAIN with count=2 -> out_valid=0, count=0, shift_enable=0 immediately; no drain_done after release.
